// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state types for the UART packet link.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        TX_IDLE  = 3'd0,
        TX_START = 3'd1,
        TX_DATA  = 3'd2,
        TX_STOP  = 3'd3,
        TX_NEXT  = 3'd4
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_HUNT    = 2'd0,
        RX_PAYLOAD = 2'd1,
        RX_CHECK   = 2'd2,
        RX_COMMIT  = 2'd3
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_rx_byte.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_byte
// Description : 8N1 byte receiver: synchroniser, start qualification,
//               centre sampling, byte and framing-error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_valid,
    output logic       o_frame_err,
    output logic       o_busy
);
    import uart_pkg::*;

    localparam int             c_CW   = $clog2(CLKS_PER_BIT);
    localparam logic [c_CW-1:0] c_HALF = c_CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CW-1:0] c_FULL = c_CW'(CLKS_PER_BIT - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_START = 2'd1;
    localparam logic [1:0] c_S_DATA  = 2'd2;
    localparam logic [1:0] c_S_STOP  = 2'd3;

    logic            r_sync1;
    logic            r_sync2;
    logic            r_prev;
    logic [1:0]      r_state;
    logic [c_CW-1:0] r_cnt;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;

    assign o_byte = r_shift;
    assign o_busy = (r_state != c_S_IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            // Synchroniser resets to the idle line level so reset exit cannot fake a start edge
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_prev       <= 1'b1;
            r_state      <= c_S_IDLE;
            r_cnt        <= '0;
            r_bit        <= '0;
            r_shift      <= '0;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
        end else begin
            r_sync1      <= i_rx;
            r_sync2      <= r_sync1;
            r_prev       <= r_sync2;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (r_prev && !r_sync2) begin
                        r_state <= c_S_START;
                        r_cnt   <= '0;
                    end
                end
                c_S_START: begin
                    if (r_cnt == c_HALF) begin
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_state <= r_sync2 ? c_S_IDLE : c_S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_S_DATA: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt   <= '0;
                        r_shift <= {r_sync2, r_shift[7:1]};
                        if (r_bit == 3'd7) begin
                            r_state <= c_S_STOP;
                        end else begin
                            r_bit <= r_bit + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                c_S_STOP: begin
                    if (r_cnt == c_FULL) begin
                        r_cnt        <= '0;
                        r_state      <= c_S_IDLE;
                        o_byte_valid <= r_sync2;
                        o_frame_err  <= !r_sync2;
                    end else begin
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_packet_xcvr.sv
`default_nettype none
// ============================================================================
// Module      : uart_packet_xcvr
// Description : Packetised UART transceiver: sync byte, MSB-first payload,
//               optional XOR checksum; independent TX and RX paths.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_packet_xcvr #(
    parameter int PAYLOAD_BYTES = 10,
    parameter int CLKS_PER_BIT  = 100,
    parameter int CHECKSUM_EN   = 1,
    parameter int TIMEOUT_BITS  = 20
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       RX,
    input  logic [8*PAYLOAD_BYTES-1:0] idata,
    input  logic                       senddata,
    output logic                       TX,
    output logic                       tx_busy,
    output logic [8*PAYLOAD_BYTES-1:0] odata,
    output logic                       datavalid,
    output logic                       rx_err
);
    import uart_pkg::*;

    localparam int c_W        = 8 * PAYLOAD_BYTES;
    localparam int c_NBYTES   = PAYLOAD_BYTES + 1 + ((CHECKSUM_EN != 0) ? 1 : 0);
    localparam int c_IW       = $clog2(c_NBYTES);
    localparam int c_PKT_SZ   = 2 ** c_IW;
    localparam int c_PW       = $clog2(PAYLOAD_BYTES + 1);
    localparam int c_BW       = $clog2(CLKS_PER_BIT);
    // The stop bit is sampled mid-bit, so half a bit is added to measure the true line gap
    localparam int c_TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT + CLKS_PER_BIT / 2;
    localparam int c_TW       = $clog2(c_TO_LIMIT + 1);

    localparam logic [c_BW-1:0] c_BIT_END  = c_BW'(CLKS_PER_BIT - 1);
    localparam logic [c_IW-1:0] c_LAST_IDX = c_IW'(c_NBYTES - 1);
    localparam logic [c_PW-1:0] c_LAST_PAY = c_PW'(PAYLOAD_BYTES - 1);
    localparam logic [c_TW-1:0] c_TO_END   = c_TW'(c_TO_LIMIT);

    // ---------------- TX path ----------------
    tx_state_t       r_tx_state;
    logic [c_W-1:0]  r_tx_data;
    logic [c_BW-1:0] r_tx_cnt;
    logic [2:0]      r_bit_idx;
    logic [c_IW-1:0] r_byte_idx;
    logic [7:0]      w_csum;
    logic [7:0]      w_pkt [c_PKT_SZ];
    logic [7:0]      w_cur_byte;

    always_comb begin
        w_csum = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            w_csum = w_csum ^ r_tx_data[8*i +: 8];
        end
        for (int i = 0; i < c_PKT_SZ; i++) begin
            w_pkt[i] = '0;
        end
        w_pkt[0] = SYNC_BYTE;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            w_pkt[i+1] = r_tx_data[8*(PAYLOAD_BYTES-1-i) +: 8];
        end
        if (CHECKSUM_EN != 0) begin
            w_pkt[c_NBYTES-1] = w_csum;
        end
    end

    assign w_cur_byte = w_pkt[r_byte_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            TX         <= 1'b1;
            tx_busy    <= 1'b0;
            r_tx_data  <= '0;
            r_tx_cnt   <= '0;
            r_bit_idx  <= '0;
            r_byte_idx <= '0;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (senddata) begin
                        r_tx_data  <= idata;
                        tx_busy    <= 1'b1;
                        TX         <= 1'b0;
                        r_tx_cnt   <= '0;
                        r_byte_idx <= '0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == c_BIT_END) begin
                        r_tx_cnt   <= '0;
                        r_bit_idx  <= '0;
                        TX         <= w_cur_byte[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_BW'(1);
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == c_BIT_END) begin
                        r_tx_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
                            TX         <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                            TX        <= w_cur_byte[r_bit_idx + 3'd1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_BW'(1);
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == c_BIT_END) begin
                        r_tx_cnt <= '0;
                        if (r_byte_idx == c_LAST_IDX) begin
                            tx_busy    <= 1'b0;
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_byte_idx <= r_byte_idx + c_IW'(1);
                            TX         <= 1'b0;
                            r_tx_state <= TX_NEXT;
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + c_BW'(1);
                    end
                end
                // NEXT is the first clock of the following start bit, keeping bytes back to back
                TX_NEXT: begin
                    r_tx_cnt   <= r_tx_cnt + c_BW'(1);
                    r_tx_state <= TX_START;
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // ---------------- RX path ----------------
    logic [7:0] w_rx_byte;
    logic       w_byte_valid;
    logic       w_frame_err;
    logic       w_rx_busy;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx_byte (
        .clk          (clk),
        .rst          (rst),
        .i_rx         (RX),
        .o_byte       (w_rx_byte),
        .o_byte_valid (w_byte_valid),
        .o_frame_err  (w_frame_err),
        .o_busy       (w_rx_busy)
    );

    rx_state_t       r_rx_state;
    logic [c_W-1:0]  r_stage;
    logic [7:0]      r_rx_csum;
    logic [c_PW-1:0] r_pay_cnt;
    logic [c_TW-1:0] r_to_cnt;
    logic            w_in_pkt;
    logic            w_timeout;

    assign w_in_pkt  = (r_rx_state == RX_PAYLOAD) || (r_rx_state == RX_CHECK);
    assign w_timeout = (r_to_cnt == c_TO_END);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_state <= RX_HUNT;
            r_stage    <= '0;
            r_rx_csum  <= '0;
            r_pay_cnt  <= '0;
            r_to_cnt   <= '0;
            odata      <= '0;
            datavalid  <= 1'b0;
            rx_err     <= 1'b0;
        end else begin
            datavalid <= 1'b0;
            rx_err    <= 1'b0;
            r_to_cnt  <= (w_in_pkt && !w_rx_busy && !w_byte_valid) ? r_to_cnt + c_TW'(1) : '0;
            case (r_rx_state)
                RX_HUNT: begin
                    if (w_byte_valid && (w_rx_byte == SYNC_BYTE)) begin
                        r_pay_cnt  <= '0;
                        r_rx_csum  <= '0;
                        r_rx_state <= RX_PAYLOAD;
                    end
                end
                RX_PAYLOAD: begin
                    if (w_frame_err || w_timeout) begin
                        rx_err     <= 1'b1;
                        r_rx_state <= RX_HUNT;
                    end else if (w_byte_valid) begin
                        r_stage   <= (r_stage << 8) | c_W'(w_rx_byte);
                        r_rx_csum <= r_rx_csum ^ w_rx_byte;
                        if (r_pay_cnt == c_LAST_PAY) begin
                            r_rx_state <= (CHECKSUM_EN != 0) ? RX_CHECK : RX_COMMIT;
                        end else begin
                            r_pay_cnt <= r_pay_cnt + c_PW'(1);
                        end
                    end
                end
                RX_CHECK: begin
                    if (w_frame_err || w_timeout) begin
                        rx_err     <= 1'b1;
                        r_rx_state <= RX_HUNT;
                    end else if (w_byte_valid) begin
                        if (w_rx_byte == r_rx_csum) begin
                            r_rx_state <= RX_COMMIT;
                        end else begin
                            rx_err     <= 1'b1;
                            r_rx_state <= RX_HUNT;
                        end
                    end
                end
                RX_COMMIT: begin
                    odata      <= r_stage;
                    datavalid  <= 1'b1;
                    r_rx_state <= RX_HUNT;
                end
                default: r_rx_state <= RX_HUNT;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_packet_xcvr.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_packet_xcvr
// Description : Self-checking bench: loopback vectors plus injected serial
//               sequences compared against a byte-level packet model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_packet_xcvr;

    localparam int N   = 10;
    localparam int CPB = 100;
    localparam int TOB = 20;
    localparam int W   = 8 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         senddata;
    logic         tb_line;
    logic         use_loop;
    logic [W-1:0] idata;
    logic         rx_line;
    logic         TX;
    logic         tx_busy;
    logic [W-1:0] odata;
    logic         datavalid;
    logic         rx_err;

    always #5 clk = ~clk;

    assign rx_line = use_loop ? TX : tb_line;

    uart_packet_xcvr #(
        .PAYLOAD_BYTES (N),
        .CLKS_PER_BIT  (CPB),
        .CHECKSUM_EN   (1),
        .TIMEOUT_BITS  (TOB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .RX        (rx_line),
        .idata     (idata),
        .senddata  (senddata),
        .TX        (TX),
        .tx_busy   (tx_busy),
        .odata     (odata),
        .datavalid (datavalid),
        .rx_err    (rx_err)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference packet: sync, payload MSB byte first, XOR of payload bytes
    function automatic logic [7:0] pkt_byte(input logic [W-1:0] d, input int i);
        logic [7:0] x;
        if (i == 0) return 8'hA5;
        if (i <= N) return d[8*(N-i) +: 8];
        x = 8'h00;
        for (int j = 0; j < N; j++) x = x ^ d[8*j +: 8];
        return x;
    endfunction

    function automatic logic [W-1:0] rand_w();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    // Pulse / busy monitors (monotonic totals; tests take deltas)
    int dv_total = 0;
    int err_total = 0;
    int both_total = 0;
    int busy_total = 0;

    initial forever begin
        @(negedge clk);
        if (datavalid === 1'b1) dv_total++;
        if (rx_err === 1'b1) err_total++;
        if (datavalid === 1'b1 && rx_err === 1'b1) both_total++;
        if (tx_busy === 1'b1) busy_total++;
    end

    // TX line decoder
    logic [7:0] tx_log [256];
    int         tx_n = 0;
    logic       mon_prev = 1'b1;
    logic [7:0] mon_b;

    initial forever begin
        @(negedge clk);
        if (mon_prev === 1'b1 && TX === 1'b0) begin
            repeat (CPB / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
                repeat (CPB) @(negedge clk);
                mon_b[k] = TX;
            end
            repeat (CPB) @(negedge clk);
            if (tx_n < 256) tx_log[tx_n] = mon_b;
            tx_n++;
        end
        mon_prev = TX;
    end

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        tb_line = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int k = 0; k < 8; k++) begin
            tb_line = b[k];
            repeat (CPB) @(negedge clk);
        end
        tb_line = stop_bit;
        repeat (CPB) @(negedge clk);
        tb_line = 1'b1;
    endtask

    task automatic send_pkt(input logic [W-1:0] d, input logic [7:0] csum_flip);
        for (int i = 0; i < N + 2; i++) begin
            send_byte(pkt_byte(d, i) ^ ((i == N + 1) ? csum_flip : 8'h00), 1'b1);
        end
    endtask

    typedef struct {
        logic [W-1:0] data;
        logic [W-1:0] intr;
        logic [7:0]   csum;
        int           busy;
    } vec_t;

    vec_t        vt [2];
    logic [95:0] exp_stream;
    logic [W-1:0] p_good;

    initial begin
        int n0, dv0, er0, b0, t;

        vt[0] = '{data: 80'hFAAF_001F_FFFF_FAAF_AAAA, intr: 80'h0123_4567_89AB_CDEF_5A5A,
                  csum: 8'h1F, busy: 12000};
        vt[1].data = rand_w();
        vt[1].intr = ~vt[1].data;
        vt[1].csum = pkt_byte(vt[1].data, N + 1);
        vt[1].busy = 10 * CPB * (N + 2);
        exp_stream = 96'hA5_FA_AF_00_1F_FF_FF_FA_AF_AA_AA_1F;

        rst = 1'b0; senddata = 1'b0; idata = '0; tb_line = 1'b1; use_loop = 1'b1;
        repeat (5) @(negedge clk);
        chk_i("reset_TX", int'(TX), 1);
        chk_i("reset_busy", int'(tx_busy), 0);
        chk("reset_odata", odata, '0);
        chk_i("reset_datavalid", int'(datavalid), 0);
        chk_i("reset_rx_err", int'(rx_err), 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);

        // Loopback vectors, each with an ignored senddata at cycle 500
        for (int v = 0; v < 2; v++) begin
            n0 = tx_n; dv0 = dv_total; er0 = err_total; b0 = busy_total;
            use_loop = 1'b1;
            idata = vt[v].data; senddata = 1'b1;
            @(negedge clk);
            senddata = 1'b0;
            repeat (499) @(negedge clk);
            idata = vt[v].intr; senddata = 1'b1;
            @(negedge clk);
            senddata = 1'b0;
            t = 0;
            while (tx_busy && t < 20000) begin
                @(negedge clk);
                t++;
            end
            chk_i("tx_busy_fall", int'(tx_busy), 0);
            repeat (300) @(negedge clk);
            chk_i("tx_byte_count", tx_n - n0, N + 2);
            for (int i = 0; i < N + 2; i++) begin
                chk_i("tx_byte_model", int'(tx_log[(n0 + i) % 256]), int'(pkt_byte(vt[v].data, i)));
                if (v == 0) chk_i("tx_byte_fixed", int'(tx_log[(n0 + i) % 256]), int'(exp_stream[8*(11-i) +: 8]));
            end
            chk_i("tx_csum", int'(tx_log[(n0 + N + 1) % 256]), int'(vt[v].csum));
            chk_i("busy_cycles", busy_total - b0, vt[v].busy);
            chk("loop_odata", odata, vt[v].data);
            chk_i("loop_dv_pulses", dv_total - dv0, 1);
            chk_i("loop_err_pulses", err_total - er0, 0);
            chk_i("no_second_pkt", int'(tx_busy), 0);
        end

        // Reset in the middle of a loopback packet
        idata = rand_w(); senddata = 1'b1;
        @(negedge clk);
        senddata = 1'b0;
        repeat (3000) @(negedge clk);
        dv0 = dv_total; er0 = err_total;
        rst = 1'b0;
        @(negedge clk);
        chk_i("midrst_TX", int'(TX), 1);
        chk_i("midrst_busy", int'(tx_busy), 0);
        chk("midrst_odata", odata, '0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (1500) @(negedge clk);
        chk_i("midrst_dv", dv_total - dv0, 0);
        chk_i("midrst_err", err_total - er0, 0);
        chk_i("midrst_idle_TX", int'(TX), 1);

        // Truncated packet -> timeout, junk bytes in HUNT, then a good packet
        use_loop = 1'b0; tb_line = 1'b1;
        repeat (20) @(negedge clk);
        dv0 = dv_total; er0 = err_total;
        p_good = rand_w();
        for (int i = 0; i < 5; i++) send_byte(pkt_byte(p_good, i), 1'b1);
        t = 0;
        while (err_total == er0 && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk_i("timeout_pulse", err_total - er0, 1);
        chk_i("timeout_window", int'(t >= TOB * CPB && t <= TOB * CPB + CPB), 1);
        repeat (50) @(negedge clk);
        send_byte(8'h00, 1'b1);
        send_byte(8'h55, 1'b1);
        p_good = rand_w();
        send_pkt(p_good, 8'h00);
        repeat (300) @(negedge clk);
        chk("after_junk_odata", odata, p_good);
        chk_i("after_junk_dv", dv_total - dv0, 1);
        chk_i("after_junk_err", err_total - er0, 1);

        // Checksum 0x1E instead of 0x1F
        dv0 = dv_total; er0 = err_total;
        send_pkt(vt[0].data, 8'h01);
        repeat (300) @(negedge clk);
        chk_i("badcsum_err", err_total - er0, 1);
        chk_i("badcsum_dv", dv_total - dv0, 0);
        chk("badcsum_odata", odata, p_good);

        // Framing errors: silent in HUNT, reported inside a packet
        er0 = err_total; dv0 = dv_total;
        send_byte(8'h3C, 1'b0);
        repeat (200) @(negedge clk);
        chk_i("frame_hunt_err", err_total - er0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h81, 1'b0);
        repeat (200) @(negedge clk);
        chk_i("frame_pkt_err", err_total - er0, 1);
        chk_i("frame_pkt_dv", dv_total - dv0, 0);
        chk("frame_odata", odata, p_good);

        chk_i("dv_err_overlap", both_total, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_packet_xcvr.md
UART_PACKET_XCVR -- requirements
Module: uart_packet_xcvr

Interface
REQ-001 Parameter PAYLOAD_BYTES, default 10, sets payload bytes per packet (1..32); data width is W = 8*PAYLOAD_BYTES.
REQ-002 Parameter CLKS_PER_BIT, default 100, sets the baud divisor in clocks per UART bit (>=16).
REQ-003 Parameter CHECKSUM_EN, default 1, appends and checks an XOR checksum byte when 1.
REQ-004 Parameter TIMEOUT_BITS, default 20, sets the RX inter-byte idle limit in bit times.
REQ-005 clk  in  1  single system clock, rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 RX  in  1  UART serial input, asynchronous to clk.
REQ-008 idata  in  W  payload to transmit.
REQ-009 senddata  in  1  one-cycle transmit request.
REQ-010 TX  out  1  UART serial output, idle high.
REQ-011 tx_busy  out  1  high while a packet is being transmitted.
REQ-012 odata  out  W  last good received payload.
REQ-013 datavalid  out  1  one-cycle pulse when odata updates.
REQ-014 rx_err  out  1  one-cycle pulse on a checksum, framing or timeout error.

Function
REQ-015 The link SHALL use 8N1 framing: start bit 0, 8 data bits LSB first, stop bit 1, each bit CLKS_PER_BIT clocks long.
REQ-016 A packet SHALL be sent in this order: sync byte 0xA5, payload bytes most-significant byte first (idata[W-1:W-8] first), then the checksum byte if CHECKSUM_EN=1.
REQ-017 The checksum SHALL be the XOR of the payload bytes only; the sync byte is excluded.
REQ-018 The TX FSM SHALL have the states IDLE, START, DATA, STOP and NEXT.
REQ-019 In IDLE with senddata=1, the TX SHALL latch idata, assert tx_busy and drive the start bit on the following cycle.
REQ-020 senddata asserted while tx_busy=1 SHALL be ignored, and the latched data SHALL NOT change.
REQ-021 tx_busy SHALL deassert in the cycle after the last stop bit completes.
REQ-022 tx_busy total = 10*CLKS_PER_BIT*(PAYLOAD_BYTES+1+CHECKSUM_EN) cycles.
REQ-023 RX SHALL pass RX through a 2-flop synchroniser.
REQ-024 RX SHALL detect the falling edge of a start bit and confirm it with a low sample at CLKS_PER_BIT/2.
REQ-025 RX SHALL then sample each data bit and the stop bit at bit centre.
REQ-026 The RX packet FSM SHALL have the states HUNT, PAYLOAD, CHECK and COMMIT.
REQ-027 In HUNT, RX SHALL discard every byte that is not 0xA5 without any pulse.
REQ-028 Received payload bytes SHALL shift into a W-bit staging register; odata SHALL NOT change until COMMIT.
REQ-029 On a checksum match (or when CHECKSUM_EN=0), RX SHALL copy the staging register to odata and pulse datavalid in the same cycle.
REQ-030 On a checksum mismatch, RX SHALL pulse rx_err, hold odata and return to HUNT.
REQ-031 A stop bit sampled as 0 outside HUNT SHALL pulse rx_err and return RX to HUNT.
REQ-032 A stop bit sampled as 0 inside HUNT SHALL be ignored silently.
REQ-033 An idle gap of more than TIMEOUT_BITS*CLKS_PER_BIT cycles between bytes in PAYLOAD or CHECK SHALL pulse rx_err and return RX to HUNT.
REQ-034 TX and RX SHALL run fully independently; simultaneous transmit and receive (including loopback TX->RX) SHALL be supported.
REQ-035 datavalid and rx_err SHALL never assert in the same cycle.

Reset
REQ-036 While rst=0 at a clock edge: TX=1, tx_busy=0, odata=0, datavalid=0, rx_err=0, both FSMs to IDLE/HUNT, all counters to 0.
REQ-037 Reset during a transfer SHALL abort it immediately with no partial odata update and no error pulse.

Structure
REQ-038 Package uart_pkg SHALL hold SYNC_BYTE=8'hA5 and the TX and RX state enum typedefs.
REQ-039 One sub-module, uart_rx_byte, SHALL hold the synchroniser, start detection, bit sampling and byte/framing-error output; the packet FSMs and the TX path stay top-level.

Verification
REQ-040 Loopback with defaults, idata=80'hFAAF_001F_FFFF_FAAF_AAAA, 1-cycle senddata -> TX byte stream A5 FA AF 00 1F FF FF FA AF AA AA 1F; odata equals idata; exactly one datavalid pulse; tx_busy high for 12000 cycles.
REQ-041 Inject a packet with checksum byte 0x1E instead of 0x1F -> one rx_err pulse, odata unchanged, no datavalid.
REQ-042 Send bytes 0x00 0x55, then a valid packet -> the leading bytes are discarded and the packet is received correctly.
REQ-043 Stop transmitting after the 4th payload byte -> rx_err pulses 2000 cycles (plus up to one bit time) after the last stop bit; a following packet is received correctly.
REQ-044 Pulse senddata at cycle 500 of a transfer with a different idata -> the transmitted stream is unchanged and no second packet is sent.
REQ-045 Assert rst mid-packet on both TX and RX -> TX=1 on the next edge, odata=0, no pulses; a subsequent packet completes normally.
